// File: rtl/tick_rate_ctrl.sv
// Fractional clock-enable generator: NUM evenly spaced tick pulses per DEN-cycle window.
// New ratios arrive over valid/ready and take effect only on a window boundary.
module tick_rate_ctrl #(
  parameter int          W       = 16,
  parameter int unsigned DEF_NUM = 13,
  parameter int unsigned DEF_DEN = 20
) (
  input  logic         inclk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_num,
  input  logic [W-1:0] cfg_den,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         tick,
  output logic         win_start,
  output logic         busy,
  output logic [W-1:0] cur_num,
  output logic [W-1:0] cur_den
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_num_q, cur_num_d;
  logic [W-1:0] cur_den_q, cur_den_d;
  logic [W-1:0] pend_num_q, pend_num_d;
  logic [W-1:0] pend_den_q, pend_den_d;
  logic         pend_q, pend_d;
  logic         tick_q, tick_d;
  logic         win_start_q, win_start_d;
  logic         cfg_err_q, cfg_err_d;
  logic         busy_q, busy_d;
  logic         cfg_ready_q, cfg_ready_d;

  logic [W:0]   sum;
  logic         hit;
  logic         at_end;
  logic         xfer;
  logic         cfg_ok;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, cur_num_q};
    hit    = (sum >= {1'b0, cur_den_q});
    at_end = (cnt_q == (cur_den_q - ONE));
    xfer   = cfg_valid & cfg_ready_q;
    cfg_ok = (cfg_den != '0) && (cfg_num != '0) && (cfg_num <= cfg_den);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cur_num_d   = cur_num_q;
    cur_den_d   = cur_den_q;
    pend_num_d  = pend_num_q;
    pend_den_d  = pend_den_q;
    pend_d      = pend_q;
    tick_d      = 1'b0;
    win_start_d = 1'b0;
    cfg_err_d   = xfer & ~cfg_ok;

    case (state_q)
      IDLE: begin
        if (xfer && cfg_ok) begin
          cur_num_d = cfg_num;
          cur_den_d = cfg_den;
        end
        if (en) begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          // Leaving RUN is always a clean boundary, so a queued ratio lands here too.
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          if (pend_q) begin
            cur_num_d = pend_num_q;
            cur_den_d = pend_den_q;
            pend_d    = 1'b0;
          end else if (xfer && cfg_ok) begin
            cur_num_d = cfg_num;
            cur_den_d = cfg_den;
          end
        end else begin
          tick_d      = hit;
          acc_d       = hit ? W'(sum - {1'b0, cur_den_q}) : sum[W-1:0];
          win_start_d = (cnt_q == '0);
          cnt_d       = at_end ? '0 : cnt_q + ONE;
          // The tick on the boundary edge still uses the old ratio; only the next window changes.
          if (pend_q && at_end) begin
            cur_num_d = pend_num_q;
            cur_den_d = pend_den_q;
            acc_d     = '0;
            cnt_d     = '0;
            pend_d    = 1'b0;
          end else if (xfer && cfg_ok) begin
            pend_d     = 1'b1;
            pend_num_d = cfg_num;
            pend_den_d = cfg_den;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == RUN);
    cfg_ready_d = ~pend_d;
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      cur_num_q   <= W'(DEF_NUM);
      cur_den_q   <= W'(DEF_DEN);
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
      win_start_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cur_num_q   <= cur_num_d;
      cur_den_q   <= cur_den_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
      win_start_q <= win_start_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  // Pending ratio payload is only meaningful while pend_q is set.
  always_ff @(posedge inclk) begin
    pend_num_q <= pend_num_d;
    pend_den_q <= pend_den_d;
  end

  assign tick      = tick_q;
  assign win_start = win_start_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;
  assign cur_num   = cur_num_q;
  assign cur_den   = cur_den_q;

endmodule

// File: doc/tick_rate_ctrl.md
Name: tick_rate_ctrl

Overview:
Runtime-configurable fractional clock-enable generator and controller. It produces exactly NUM single-cycle `tick` pulses in every DEN-cycle window of `inclk`, evenly distributed using accumulator (Bresenham) spacing. Game-logic blocks use it in place of hard-wired divide chains for paddle, ball and refresh rates. Ratio changes arrive over a valid/ready handshake and are deferred to a window boundary, so no partial window ever runs at a mixed rate.

Parameters:
W, 16, width of the numerator, the denominator and all internal counters.
DEF_NUM, 13, numerator loaded at reset.
DEF_DEN, 20, denominator loaded at reset.

Ports:
inclk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run enable; level-sensitive.
cfg_valid  input  1  new ratio offered.
cfg_num  input  W  requested numerator.
cfg_den  input  W  requested denominator.
cfg_ready  output  1  a ratio can be accepted this cycle.
cfg_err  output  1  one-cycle pulse: the offered ratio was rejected.
tick  output  1  one-cycle clock-enable pulse.
win_start  output  1  one-cycle pulse marking the first cycle of each window.
busy  output  1  state is RUN.
cur_num  output  W  active numerator.
cur_den  output  W  active denominator.

Behaviour:
Reset (asynchronous, `rst_n`=0):
- state=IDLE, acc=0, cnt=0, pending cleared.
- cur_num=DEF_NUM, cur_den=DEF_DEN.
- tick=0, win_start=0, cfg_err=0, busy=0, cfg_ready=1.
- Reset mid-run discards any pending ratio. The first rising edge after release behaves as IDLE.

States:
- IDLE: tick=0, win_start=0. `en`=1 at an edge -> RUN with acc=0, cnt=0.
- RUN: `en`=0 at an edge -> IDLE. acc and cnt are cleared, and tick/win_start are 0 from the next cycle.

Datapath, each RUN edge:
- sum = acc + cur_num, computed at W+1 bits.
- tick <= (sum >= cur_den); acc <= tick ? sum - cur_den : sum.
- win_start <= (cnt == 0).
- cnt <= (cnt == cur_den-1) ? 0 : cnt+1.
- tick and win_start are registered, so both lag the cnt value that produced them by 1 cycle and are aligned with each other.
- acc returns to 0 after exactly cur_den steps, so each window holds exactly cur_num ticks.
- cur_num == cur_den gives tick=1 on every RUN cycle.

Configuration validity:
- Valid ratio: cfg_den >= 1 and 1 <= cfg_num <= cfg_den.
- An invalid ratio is still accepted: cfg_err=1 for the next cycle, nothing is stored, and cfg_ready stays 1.

Handshake (transfer when cfg_valid & cfg_ready):
- In IDLE, a valid ratio loads cur_num/cur_den at that edge; cfg_ready stays 1.
- In RUN, a valid ratio goes into the pending register and cfg_ready=0 from the next cycle.
- Pending is applied at the first edge where pending is already set and cnt == cur_den-1. At that edge cur_* are loaded, acc=0, cnt=0, pending cleared, and cfg_ready returns to 1 on the following cycle.
- A transfer accepted in the cnt == cur_den-1 cycle waits one full window.
- The old ratio governs the tick computed on the boundary edge; the new window starts with win_start under the new ratio.

Simultaneous events:
- en falls while pending is set: enter IDLE and apply pending at the same edge.
- en rises and a transfer occurs in IDLE: load the new ratio and start RUN with it at the same edge.
- cfg_valid held while cfg_ready=0: ignored, no error raised.

Test Plan:
- Reset, en=1 with defaults 13/20: over the 20 tick cycles after the first win_start the pattern is 0,1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1 (13 ones). win_start recurs every 20 cycles.
- cfg 1/4 in IDLE, then en=1: tick on every 4th cycle, on the 4th step of each window; win_start every 4 cycles; cfg_ready never drops.
- Running at 13/20, offer 3/5 at cnt=7: cfg_ready=0 until the window ends. The window still yields 13 ticks, then 3 ticks per 5 cycles follow, and cur_num/cur_den read back 3/5.
- Offer 6/5, then 0/8, then 4/0: cfg_err pulses once for each; cur_* unchanged; tick pattern undisturbed.
- Running 2/3 with a pending 1/2, drop en mid-window: tick=0 next cycle, cur=1/2 immediately. Re-enable: 1 tick per 2 cycles from a fresh window.
- Assert rst_n=0 asynchronously mid-window with pending set: tick, busy and win_start go 0 without waiting for an edge, cfg_ready=1, cur=13/20, pending discarded.
